// File: rtl/imem_loader_if.sv
// Loader bus: program-load control, byte stream handshake and fetch read port.
interface imem_loader_if;
    logic        load_start;
    logic [6:0]  load_words;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic [7:0]  pc;
    logic [31:0] instruction;
    logic        core_rst;
    logic        load_done;
    logic        load_err;
    logic [6:0]  words_loaded;

    modport master (
        output load_start, load_words, byte_valid, byte_data, pc,
        input  byte_ready, instruction, core_rst, load_done, load_err, words_loaded
    );

    modport slave (
        input  load_start, load_words, byte_valid, byte_data, pc,
        output byte_ready, instruction, core_rst, load_done, load_err, words_loaded
    );
endinterface

// File: rtl/imem_loader.sv
// Instruction memory loader: assembles a little-endian byte stream into
// 32-bit words, holds the core in reset while loading, then serves fetches.
module imem_loader #(
    parameter int          DEPTH_WORDS = 64,
    parameter logic [31:0] NOP_WORD    = 32'h00000013
) (
    input  logic         clk,
    input  logic         rst,
    imem_loader_if.slave bus
);
    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] RUN  = 2'd2;

    logic [1:0]    state;
    logic [AW-1:0] ptr;
    logic [1:0]    bcnt;
    logic [23:0]   wbuf;
    logic [6:0]    target;
    logic [6:0]    wcnt;
    logic          done_q;
    logic          err_q;
    logic [31:0]   mem [DEPTH_WORDS];

    logic          legal;
    logic          accept;
    logic          wr_en;
    logic          last_word;
    logic [AW-1:0] rd_idx;

    assign legal     = (bus.load_words != 7'd0) && (int'(bus.load_words) <= DEPTH_WORDS);
    // A load_start in the same cycle as a byte takes priority; the byte is dropped.
    assign accept    = bus.byte_valid && (state == LOAD) && !bus.load_start;
    assign wr_en     = accept && (bcnt == 2'd3);
    assign last_word = ((wcnt + 7'd1) == target);
    assign rd_idx    = bus.pc[AW+1:2];

    assign bus.byte_ready   = (state == LOAD);
    assign bus.core_rst     = (state != RUN);
    assign bus.load_done    = done_q;
    assign bus.load_err     = err_q;
    assign bus.words_loaded = wcnt;

    // Fetch port returns a NOP while the array is being rewritten.
    always_comb begin
        bus.instruction = NOP_WORD;
        if (state != LOAD && int'(rd_idx) < DEPTH_WORDS)
            bus.instruction = mem[rd_idx];
    end

    // Control FSM, byte assembly and load bookkeeping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            ptr    <= '0;
            bcnt   <= 2'd0;
            wbuf   <= 24'd0;
            target <= 7'd0;
            wcnt   <= 7'd0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if (bus.load_start) begin
                // An illegal restart leaves any load in progress untouched.
                if (legal) begin
                    state  <= LOAD;
                    target <= bus.load_words;
                    ptr    <= '0;
                    bcnt   <= 2'd0;
                    wcnt   <= 7'd0;
                end else begin
                    err_q <= 1'b1;
                end
            end else if (accept) begin
                bcnt <= bcnt + 2'd1;
                if (bcnt != 2'd3) begin
                    wbuf[{bcnt, 3'b000} +: 8] <= bus.byte_data;
                end else begin
                    wcnt <= wcnt + 7'd1;
                    // Pointer stops at the final word so it never passes load_words-1.
                    if (last_word) begin
                        state  <= RUN;
                        done_q <= 1'b1;
                    end else begin
                        ptr <= ptr + 1'b1;
                    end
                end
            end
        end
    end

    // Instruction array; deliberately not reset so contents survive a reset.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[ptr] <= {bus.byte_data, wbuf};
    end
endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: scenario tasks with a word scoreboard read back via pc.
module tb_imem_loader;
    localparam logic [31:0] NOP = 32'h00000013;

    typedef struct {
        logic [5:0]  idx;
        logic [31:0] word;
    } sb_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    imem_loader_if bus();

    imem_loader dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int done_cnt = 0;
    sb_t sb[$];
    logic [31:0] words[64];

    // Count load_done pulses away from the active edge.
    always @(negedge clk) if (bus.load_done === 1'b1) done_cnt++;

    initial begin
        #2000000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.byte_valid = 1'b1;
        bus.byte_data  = b;
        tick();
        bus.byte_valid = 1'b0;
    endtask

    task automatic start_load(input logic [6:0] n);
        bus.load_start = 1'b1;
        bus.load_words = n;
        tick();
        bus.load_start = 1'b0;
        total++; if (bus.byte_ready !== 1'b1) begin bad++; $display("FAIL start_ready: got %b want 1", bus.byte_ready); end
        total++; if (bus.core_rst !== 1'b1) begin bad++; $display("FAIL start_core_rst: got %b want 1", bus.core_rst); end
        total++; if (bus.instruction !== NOP) begin bad++; $display("FAIL load_nop: got %h want %h", bus.instruction, NOP); end
        total++; if (bus.words_loaded !== 7'd0) begin bad++; $display("FAIL start_wcnt: got %0d want 0", bus.words_loaded); end
    endtask

    // Full load of words[0..n-1]; optional idle gap between bytes.
    task automatic do_load(input int n, input bit gap);
        int d0;
        d0 = done_cnt;
        start_load(7'(n));
        for (int w = 0; w < n; w++) begin
            for (int b = 0; b < 4; b++) begin
                send_byte(words[w][8*b +: 8]);
                if (gap && !(w == n-1 && b == 3)) begin
                    total++; if (bus.byte_ready !== 1'b1) begin bad++; $display("FAIL gap_ready: got %b want 1 (w=%0d b=%0d)", bus.byte_ready, w, b); end
                    tick();
                end
            end
            sb.push_back('{idx: 6'(w), word: words[w]});
        end
        total++; if (bus.load_done !== 1'b1) begin bad++; $display("FAIL done_pulse: got %b want 1", bus.load_done); end
        total++; if (bus.core_rst !== 1'b0) begin bad++; $display("FAIL core_rst_fall: got %b want 0", bus.core_rst); end
        tick();
        total++; if (bus.load_done !== 1'b0) begin bad++; $display("FAIL done_width: got %b want 0", bus.load_done); end
        total++; if (done_cnt - d0 !== 1) begin bad++; $display("FAIL done_count: got %0d want 1", done_cnt - d0); end
        total++; if (bus.words_loaded !== 7'(n)) begin bad++; $display("FAIL words_loaded: got %0d want %0d", bus.words_loaded, n); end
    endtask

    // Drain scoreboard: read each expected word back with random pc[1:0].
    task automatic check_mem();
        sb_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            bus.pc = {e.idx, 2'($urandom_range(3))};
            #1;
            total++; if (bus.instruction !== e.word) begin bad++; $display("FAIL mem[%0d]: got %h want %h", e.idx, bus.instruction, e.word); end
        end
    endtask

    task automatic test_reset();
        #1;
        total++; if (bus.core_rst !== 1'b1) begin bad++; $display("FAIL rst_core_rst: got %b want 1", bus.core_rst); end
        total++; if (bus.byte_ready !== 1'b0) begin bad++; $display("FAIL rst_ready: got %b want 0", bus.byte_ready); end
        total++; if (bus.load_done !== 1'b0) begin bad++; $display("FAIL rst_done: got %b want 0", bus.load_done); end
        total++; if (bus.load_err !== 1'b0) begin bad++; $display("FAIL rst_err: got %b want 0", bus.load_err); end
        total++; if (bus.words_loaded !== 7'd0) begin bad++; $display("FAIL rst_wcnt: got %0d want 0", bus.words_loaded); end
        tick();
        rst = 1'b1;
        tick();
        total++; if (bus.core_rst !== 1'b1) begin bad++; $display("FAIL idle_core_rst: got %b want 1", bus.core_rst); end
    endtask

    task automatic test_basic_load();
        words[0] = 32'h00000013;
        words[1] = 32'h00100093;
        do_load(2, 1'b0);
        bus.pc = 8'h04;
        #1;
        total++; if (bus.instruction !== 32'h00100093) begin bad++; $display("FAIL pc04: got %h want 00100093", bus.instruction); end
        check_mem();
    endtask

    task automatic test_gapped_load();
        do_load(2, 1'b1);
        check_mem();
    endtask

    task automatic test_illegal();
        logic [6:0] bad_n[2];
        bad_n[0] = 7'd0;
        bad_n[1] = 7'd65;
        for (int i = 0; i < 2; i++) begin
            bus.load_start = 1'b1;
            bus.load_words = bad_n[i];
            bus.byte_valid = 1'b1;
            bus.byte_data  = 8'hFF;
            tick();
            bus.load_start = 1'b0;
            total++; if (bus.load_err !== 1'b1) begin bad++; $display("FAIL err_pulse(%0d): got %b want 1", bad_n[i], bus.load_err); end
            total++; if (bus.core_rst !== 1'b0) begin bad++; $display("FAIL err_core_rst(%0d): got %b want 0", bad_n[i], bus.core_rst); end
            total++; if (bus.byte_ready !== 1'b0) begin bad++; $display("FAIL err_ready(%0d): got %b want 0", bad_n[i], bus.byte_ready); end
            tick();
            total++; if (bus.load_err !== 1'b0) begin bad++; $display("FAIL err_width(%0d): got %b want 0", bad_n[i], bus.load_err); end
            total++; if (bus.words_loaded !== 7'd2) begin bad++; $display("FAIL err_wcnt(%0d): got %0d want 2", bad_n[i], bus.words_loaded); end
            bus.byte_valid = 1'b0;
        end
        sb.push_back('{idx: 6'd0, word: 32'h00000013});
        sb.push_back('{idx: 6'd1, word: 32'h00100093});
        check_mem();
    endtask

    task automatic test_abort();
        logic [7:0] part[6];
        part = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        start_load(7'd2);
        for (int i = 0; i < 6; i++) begin
            send_byte(part[i]);
            if (i == 1) begin
                bus.load_start = 1'b1;
                bus.load_words = 7'd0;
                tick();
                bus.load_start = 1'b0;
                total++; if (bus.load_err !== 1'b1) begin bad++; $display("FAIL load_err_in_load: got %b want 1", bus.load_err); end
                total++; if (bus.byte_ready !== 1'b1) begin bad++; $display("FAIL load_continues: got %b want 1", bus.byte_ready); end
            end
        end
        total++; if (bus.words_loaded !== 7'd1) begin bad++; $display("FAIL abort_pre_wcnt: got %0d want 1", bus.words_loaded); end
        // Restart with a byte offered in the same cycle; that byte must be dropped.
        bus.byte_valid = 1'b1;
        bus.byte_data  = 8'h77;
        words[0] = 32'hDEADBEEF;
        do_load(1, 1'b0);
        sb.push_back('{idx: 6'd1, word: 32'h00100093});
        check_mem();
    endtask

    task automatic test_reset_mid_load();
        start_load(7'd3);
        for (int i = 1; i <= 5; i++) send_byte(8'(i));
        #2 rst = 1'b0;
        #1;
        total++; if (bus.core_rst !== 1'b1) begin bad++; $display("FAIL mid_rst_core_rst: got %b want 1", bus.core_rst); end
        total++; if (bus.byte_ready !== 1'b0) begin bad++; $display("FAIL mid_rst_ready: got %b want 0", bus.byte_ready); end
        total++; if (bus.words_loaded !== 7'd0) begin bad++; $display("FAIL mid_rst_wcnt: got %0d want 0", bus.words_loaded); end
        sb.push_back('{idx: 6'd0, word: 32'h04030201});
        sb.push_back('{idx: 6'd1, word: 32'h00100093});
        check_mem();
        tick();
        rst = 1'b1;
        tick();
        words[0] = 32'hA5A5A5A5;
        words[1] = 32'h5A5A5A5A;
        do_load(2, 1'b0);
        check_mem();
    endtask

    task automatic test_full_load();
        for (int i = 0; i < 64; i++) words[i] = $urandom;
        do_load(64, 1'b0);
        bus.pc = 8'hFC;
        #1;
        total++; if (bus.instruction !== words[63]) begin bad++; $display("FAIL pc_fc: got %h want %h", bus.instruction, words[63]); end
        check_mem();
    endtask

    initial begin
        bus.load_start = 1'b0;
        bus.load_words = 7'd0;
        bus.byte_valid = 1'b0;
        bus.byte_data  = 8'h00;
        bus.pc         = 8'h00;
        test_reset();
        test_basic_load();
        test_gapped_load();
        test_illegal();
        test_abort();
        test_reset_mid_load();
        test_full_load();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
